vga_compositor: RTL and testbench

Parametrised VGA raster engine and layer compositor, successor to the fixed 640x480 graphics top. Derives a pixel enable from the system clock, runs programmable horizontal/vertical timing, publishes active-area pixel coordinates to NUM_LAYERS sprite/board/paddle generators, and merges their colour and "on" flags by fixed priority into registered RGB332 with sync aligned to the colour pipeline. It adds a frame-synchronous colour-bar test mode and a frame counter.

---
 rtl/vga_compositor.sv | 156 +++++++++++++++
 tb/tb_vga_compositor.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_compositor.sv
// rtl/vga_compositor.sv - parametrised VGA raster timing and priority layer compositor
module vga_compositor #(
  parameter int CLK_DIV    = 2,
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter bit SYNC_POL   = 1'b0,
  parameter int NUM_LAYERS = 4
) (
  input  logic                    clk50M,
  input  logic                    reset,
  input  logic [NUM_LAYERS-1:0]   layer_on,
  input  logic [8*NUM_LAYERS-1:0] layer_rgb,
  input  logic [7:0]              bg_rgb,
  input  logic                    test_mode,
  output logic [9:0]              xpixel,
  output logic [9:0]              ypixel,
  output logic                    pix_ce,
  output logic [2:0]              red,
  output logic [2:0]              green,
  output logic [1:0]              blue,
  output logic                    HS,
  output logic                    VS,
  output logic                    endofframe,
  output logic [15:0]             frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0]  H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0]  H_ACT   = 10'(H_ACTIVE);
  localparam logic [9:0]  V_ACT   = 10'(V_ACTIVE);
  // sync windows kept 11 bits wide so a 1024-count total cannot overflow the end bound
  localparam logic [10:0] H_SS    = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SE    = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_SS    = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] V_SE    = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [12:0] BAR_DEN = 13'(H_ACTIVE);

  logic [DIV_W-1:0] r_div;
  logic             r_pix_ce;
  logic [9:0]       r_hcount;
  logic [9:0]       r_vcount;
  logic             r_mode_q;
  logic [15:0]      r_frame_count;
  logic [7:0]       r_rgb;
  logic             r_hs;
  logic             r_vs;

  logic       w_h_last;
  logic       w_v_last;
  logic       w_eof;
  logic       w_active;
  logic       w_hs_raw;
  logic       w_vs_raw;
  logic [2:0] w_bar_idx;
  logic [7:0] w_layer_rgb;
  logic [7:0] w_pix_rgb;

  assign w_h_last  = (r_hcount == H_LAST);
  assign w_v_last  = (r_vcount == V_LAST);
  assign w_eof     = r_pix_ce & w_h_last & w_v_last;
  assign w_active  = (r_hcount < H_ACT) && (r_vcount < V_ACT);
  assign w_hs_raw  = ({1'b0, r_hcount} >= H_SS) && ({1'b0, r_hcount} < H_SE);
  assign w_vs_raw  = ({1'b0, r_vcount} >= V_SS) && ({1'b0, r_vcount} < V_SE);
  assign w_bar_idx = 3'({r_hcount, 3'b000} / BAR_DEN);

  // pixel-rate divider; pix_ce is registered so it is low in reset even when CLK_DIV=1
  always_ff @(posedge clk50M) begin
    if (!reset) begin
      r_div    <= '0;
      r_pix_ce <= 1'b0;
    end else if (r_div == DIV_LAST) begin
      r_div    <= '0;
      r_pix_ce <= 1'b1;
    end else begin
      r_div    <= r_div + 1'b1;
      r_pix_ce <= 1'b0;
    end
  end

  // horizontal and vertical raster counters, count 0 is the first active pixel/line
  always_ff @(posedge clk50M) begin
    if (!reset) begin
      r_hcount <= '0;
      r_vcount <= '0;
    end else if (r_pix_ce) begin
      if (w_h_last) begin
        r_hcount <= '0;
        r_vcount <= w_v_last ? 10'd0 : r_vcount + 10'd1;
      end else begin
        r_hcount <= r_hcount + 10'd1;
      end
    end
  end

  // frame counter and frame-synchronous test-mode latch
  always_ff @(posedge clk50M) begin
    if (!reset) begin
      r_mode_q      <= 1'b0;
      r_frame_count <= '0;
    end else if (w_eof) begin
      r_mode_q      <= test_mode;
      r_frame_count <= r_frame_count + 16'd1;
    end
  end

  // fixed-priority layer merge: lowest-numbered covering layer wins, else background
  always_comb begin
    w_layer_rgb = bg_rgb;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (layer_on[i]) w_layer_rgb = layer_rgb[8*i +: 8];
    end
  end

  // pixel colour: black in blanking, colour bars in test mode, merged layers otherwise
  always_comb begin
    w_pix_rgb = 8'h00;
    if (w_active) begin
      if (r_mode_q) w_pix_rgb = {{3{w_bar_idx[2]}}, {3{w_bar_idx[1]}}, {2{w_bar_idx[0]}}};
      else          w_pix_rgb = w_layer_rgb;
    end
  end

  // one-pixel output stage; syncs share it so their edges line up with the colour
  always_ff @(posedge clk50M) begin
    if (!reset) begin
      r_rgb <= 8'h00;
      r_hs  <= ~SYNC_POL;
      r_vs  <= ~SYNC_POL;
    end else if (r_pix_ce) begin
      r_rgb <= w_pix_rgb;
      r_hs  <= w_hs_raw ? SYNC_POL : ~SYNC_POL;
      r_vs  <= w_vs_raw ? SYNC_POL : ~SYNC_POL;
    end
  end

  assign xpixel             = r_hcount;
  assign ypixel             = r_vcount;
  assign pix_ce             = r_pix_ce;
  assign {red, green, blue} = r_rgb;
  assign HS                 = r_hs;
  assign VS                 = r_vs;
  assign endofframe         = w_eof;
  assign frame_count        = r_frame_count;

endmodule

// File: tb/tb_vga_compositor.sv
// tb/tb_vga_compositor.sv - randomized and directed checks of vga_compositor against a raster model
module tb_vga_compositor;

  localparam int CD = 2;
  localparam int HA = 16, HFP = 2, HSY = 3, HBP = 3, HT = HA + HFP + HSY + HBP;
  localparam int VA = 6,  VFP = 1, VSY = 2, VBP = 1, VT = VA + VFP + VSY + VBP;
  localparam int NL = 4;
  localparam int FRAME = HT * VT * CD;

  logic          clk = 1'b0;
  logic          reset;
  logic [NL-1:0] layer_on;
  logic [8*NL-1:0] layer_rgb;
  logic [7:0]    bg_rgb;
  logic          test_mode;
  logic [9:0]    xpixel, ypixel;
  logic          pix_ce;
  logic [2:0]    red, green;
  logic [1:0]    blue;
  logic          HS, VS, endofframe;
  logic [15:0]   frame_count;

  int          n_checks = 0;
  int          n_fail = 0;
  int          t = 0;
  bit          rand_en = 1'b1;
  bit          m_mode = 1'b0;
  logic [9:0]  exp_x, exp_y;
  logic        exp_pce, exp_eof, exp_hs, exp_vs;
  logic [7:0]  exp_rgb;
  logic [15:0] exp_fc;
  int          last_h = 0;
  bit          last_act = 1'b0;

  vga_compositor #(
    .CLK_DIV(CD), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP), .SYNC_POL(1'b0), .NUM_LAYERS(NL)
  ) dut (
    .clk50M(clk), .reset(reset), .layer_on(layer_on), .layer_rgb(layer_rgb), .bg_rgb(bg_rgb),
    .test_mode(test_mode), .xpixel(xpixel), .ypixel(ypixel), .pix_ce(pix_ce), .red(red),
    .green(green), .blue(blue), .HS(HS), .VS(VS), .endofframe(endofframe), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  // pixels completed after tt clock edges since reset release
  function automatic int pix_of(int tt);
    return (tt >= 1) ? (tt - 1) / CD : 0;
  endfunction

  function automatic bit pce_of(int tt);
    return (tt >= 1) && (tt % CD == 0);
  endfunction

  function automatic logic [7:0] bar(int h);
    case (h * 8 / HA)
      0: return 8'h00;
      1: return 8'h03;
      2: return 8'h1C;
      3: return 8'h1F;
      4: return 8'hE0;
      5: return 8'hE3;
      6: return 8'hFC;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic [7:0] colour(int h, int v, bit mode, logic [NL-1:0] on,
                                        logic [8*NL-1:0] rgb, logic [7:0] bg);
    if (h >= HA || v >= VA) return 8'h00;
    if (mode) return bar(h);
    for (int i = 0; i < NL; i++) if (on[i]) return rgb[8*i +: 8];
    return bg;
  endfunction

  // one clock: drive inputs at negedge, advance the model at posedge, settle before sampling
  task automatic tick();
    int p_old, h_old, v_old, p;
    @(negedge clk);
    if (rand_en) begin
      layer_on  = 4'($urandom);
      layer_rgb = 32'($urandom);
      bg_rgb    = 8'($urandom);
    end
    @(posedge clk);
    if (!reset) begin
      t = 0; m_mode = 1'b0; exp_rgb = 8'h00; exp_hs = 1'b1; exp_vs = 1'b1; last_act = 1'b0;
    end else begin
      if (pce_of(t)) begin
        p_old    = pix_of(t);
        h_old    = p_old % HT;
        v_old    = (p_old / HT) % VT;
        exp_rgb  = colour(h_old, v_old, m_mode, layer_on, layer_rgb, bg_rgb);
        exp_hs   = !(h_old >= HA + HFP && h_old < HA + HFP + HSY);
        exp_vs   = !(v_old >= VA + VFP && v_old < VA + VFP + VSY);
        last_h   = h_old;
        last_act = (h_old < HA) && (v_old < VA);
        if (h_old == HT - 1 && v_old == VT - 1) m_mode = test_mode;
      end
      t++;
    end
    p       = pix_of(t);
    exp_x   = 10'(p % HT);
    exp_y   = 10'((p / HT) % VT);
    exp_fc  = 16'(p / (HT * VT));
    exp_pce = pce_of(t);
    exp_eof = exp_pce && (p % HT == HT - 1) && ((p / HT) % VT == VT - 1);
    #1;
  endtask

  task automatic test_reset();
    int n;
    reset = 1'b1;
    n = $urandom_range(900, 600);
    repeat (n) tick();
    reset = 1'b0;
    repeat (5) begin
      tick();
      n_checks++;
      if ({xpixel, ypixel, pix_ce, red, green, blue, HS, VS, endofframe, frame_count} !==
          {10'd0, 10'd0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 16'd0}) begin
        n_fail++;
        $display("FAIL reset_values: got x=%0d y=%0d ce=%b rgb=%h hs=%b vs=%b eof=%b fc=%0d, want all zero with hs=vs=1",
                 xpixel, ypixel, pix_ce, {red, green, blue}, HS, VS, endofframe, frame_count);
      end
    end
    reset = 1'b1;
    n = 0;
    do begin tick(); n++; end while (pix_ce !== 1'b1 && n < 10);
    n_checks++;
    if (n != CD) begin
      n_fail++;
      $display("FAIL reset_first_ce: pix_ce first high after %0d clocks, want %0d", n, CD);
    end
    n_checks++;
    if (xpixel !== 10'd0 || ypixel !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_first_xy: got (%0d,%0d), want (0,0)", xpixel, ypixel);
    end
  endtask

  task automatic test_random_stream();
    for (int i = 0; i < 3 * FRAME; i++) begin
      if ($urandom_range(150, 0) == 0) test_mode = ~test_mode;
      tick();
      n_checks++;
      if ({xpixel, ypixel, pix_ce, red, green, blue, HS, VS, endofframe, frame_count} !==
          {exp_x, exp_y, exp_pce, exp_rgb, exp_hs, exp_vs, exp_eof, exp_fc}) begin
        n_fail++;
        $display("FAIL stream t=%0d: got x=%0d y=%0d ce=%b rgb=%h hs=%b vs=%b eof=%b fc=%0d, want x=%0d y=%0d ce=%b rgb=%h hs=%b vs=%b eof=%b fc=%0d",
                 t, xpixel, ypixel, pix_ce, {red, green, blue}, HS, VS, endofframe, frame_count,
                 exp_x, exp_y, exp_pce, exp_rgb, exp_hs, exp_vs, exp_eof, exp_fc);
      end
    end
    test_mode = 1'b0;
    repeat (FRAME + 2) tick();
  endtask

  task automatic test_line_timing();
    int n, low, per;
    logic prev;
    bit seen_high;
    n = 0;
    do begin prev = HS; tick(); n++; end while (!(prev === 1'b1 && HS === 1'b0) && n < 4 * HT * CD);
    n_checks++;
    if (!(prev === 1'b1 && HS === 1'b0)) begin
      n_fail++;
      $display("FAIL hs_fall_timeout: no HS falling edge in %0d clocks", n);
    end
    n_checks++;
    if (xpixel !== 10'(HA + HFP + 1)) begin
      n_fail++;
      $display("FAIL hs_fall_position: xpixel=%0d at HS fall, want %0d", xpixel, HA + HFP + 1);
    end
    low = 1; per = 0; seen_high = 1'b0;
    for (int i = 0; i < 4 * HT * CD; i++) begin
      prev = HS;
      tick();
      per++;
      if (!seen_high) begin
        if (HS === 1'b0) low++;
        else seen_high = 1'b1;
      end else if (prev === 1'b1 && HS === 1'b0) break;
    end
    n_checks++;
    if (low != HSY * CD) begin
      n_fail++;
      $display("FAIL hs_width: HS low %0d clocks, want %0d", low, HSY * CD);
    end
    n_checks++;
    if (per != HT * CD) begin
      n_fail++;
      $display("FAIL line_period: %0d clocks, want %0d", per, HT * CD);
    end
  endtask

  task automatic test_frame();
    int n, per, low;
    logic [15:0] fc0;
    logic prev;
    n = 0;
    while (endofframe !== 1'b1 && n < 2 * FRAME) begin tick(); n++; end
    fc0 = frame_count;
    tick();
    n_checks++;
    if (endofframe !== 1'b0 || frame_count !== fc0 + 16'd1) begin
      n_fail++;
      $display("FAIL eof_pulse: eof=%b fc=%0d after pulse, want eof=0 fc=%0d", endofframe, frame_count, fc0 + 16'd1);
    end
    per = 1;
    while (endofframe !== 1'b1 && per < 2 * FRAME) begin tick(); per++; end
    n_checks++;
    if (per != FRAME) begin
      n_fail++;
      $display("FAIL frame_period: eof spacing %0d clocks, want %0d", per, FRAME);
    end
    n = 0;
    do begin prev = VS; tick(); n++; end while (!(prev === 1'b1 && VS === 1'b0) && n < 2 * FRAME);
    n_checks++;
    if (xpixel !== 10'd1 || ypixel !== 10'(VA + VFP)) begin
      n_fail++;
      $display("FAIL vs_fall_position: (%0d,%0d) at VS fall, want (1,%0d)", xpixel, ypixel, VA + VFP);
    end
    low = 1;
    while (VS === 1'b0 && low < 2 * FRAME) begin tick(); if (VS === 1'b0) low++; end
    n_checks++;
    if (low != VSY * HT * CD) begin
      n_fail++;
      $display("FAIL vs_width: VS low %0d clocks, want %0d", low, VSY * HT * CD);
    end
  endtask

  task automatic test_priority();
    logic [7:0] want;
    rand_en   = 1'b0;
    layer_rgb = {8'h11, 8'h1C, 8'hE0, 8'h22};
    bg_rgb    = 8'h5A;
    for (int k = 0; k < 3; k++) begin
      case (k)
        0:       begin layer_on = 4'b0110; want = 8'hE0; end
        1:       begin layer_on = 4'b0000; want = 8'h5A; end
        default: begin layer_on = 4'b1000; want = 8'h11; end
      endcase
      repeat (2 * CD) tick();
      for (int i = 0; i < FRAME; i++) begin
        tick();
        n_checks++;
        if ({red, green, blue} !== (last_act ? want : 8'h00)) begin
          n_fail++;
          $display("FAIL priority case %0d t=%0d: rgb=%h, want %h", k, t, {red, green, blue},
                   last_act ? want : 8'h00);
        end
      end
    end
    rand_en = 1'b1;
  endtask

  task automatic test_test_mode();
    int n;
    logic [7:0] want;
    rand_en  = 1'b0;
    layer_on = '0;
    bg_rgb   = 8'h5A;
    for (int ph = 0; ph < 2; ph++) begin
      n = 0;
      while (exp_y != 10'd2 && n < 2 * FRAME) begin tick(); n++; end
      test_mode = (ph == 0);
      n = 0;
      do begin
        tick();
        n++;
        want = last_act ? ((ph == 0) ? 8'h5A : bar(last_h)) : 8'h00;
        n_checks++;
        if ({red, green, blue} !== want) begin
          n_fail++;
          $display("FAIL mode_hold ph=%0d x=%0d: rgb=%h, want %h", ph, last_h, {red, green, blue}, want);
        end
      end while (endofframe !== 1'b1 && n < 2 * FRAME);
      n_checks++;
      if (endofframe !== 1'b1) begin
        n_fail++;
        $display("FAIL mode_eof_timeout ph=%0d: eof=%b, want 1", ph, endofframe);
      end
      for (int i = 0; i < FRAME; i++) begin
        tick();
        want = last_act ? ((ph == 0) ? bar(last_h) : 8'h5A) : 8'h00;
        n_checks++;
        if ({red, green, blue} !== want) begin
          n_fail++;
          $display("FAIL mode_switch ph=%0d x=%0d: rgb=%h, want %h", ph, last_h, {red, green, blue}, want);
        end
      end
    end
    rand_en = 1'b1;
  endtask

  initial begin
    reset     = 1'b0;
    test_mode = 1'b0;
    layer_on  = '0;
    layer_rgb = '0;
    bg_rgb    = 8'h00;
    repeat (3) tick();
    test_reset();
    test_random_stream();
    test_line_timing();
    test_frame();
    test_priority();
    test_test_mode();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
